rl_step_ctrl: RTL and testbench

RL_STEP_CTRL -- requirements
Module: rl_step_ctrl

---
 rtl/rl_pkg.sv | 27 ++
 rtl/sat_acc32.sv | 39 +++
 rtl/rl_step_ctrl.sv | 162 ++++++++++++++++
 tb/tb_rl_step_ctrl.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rl_pkg.sv
// Shared types and widths for the RL step controller: FSM state encoding,
// per-intersection state word (4 lanes x 3 bits) and the latched observation pair.
package rl_pkg;

  localparam int unsigned LANE_W = 3;
  localparam int unsigned LANES  = 4;
  localparam int unsigned ST_W   = LANE_W * LANES;
  localparam int unsigned REW_W  = 32;
  localparam int unsigned STEP_W = 16;
  localparam int unsigned SET_W  = 8;
  localparam int unsigned LAT_W  = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACT    = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    EVAL   = 3'd4,
    UPDATE = 3'd5
  } rl_state_e;

  typedef struct packed {
    logic [ST_W-1:0] a;
    logic [ST_W-1:0] b;
  } rl_obs_t;

endpackage

// File: rtl/sat_acc32.sv
// Signed 32-bit accumulator that saturates at 0x7FFFFFFF / 0x80000000.
// Synchronous clear, accumulate on en; clear wins.
module sat_acc32
  import rl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [REW_W-1:0] din,
  output logic signed [REW_W-1:0] acc
);

  logic [REW_W:0]       sum_c;
  logic [REW_W-1:0]     sat_c;

  // One guard bit: top two bits differing means the add overflowed.
  assign sum_c = {acc[REW_W-1], acc} + {din[REW_W-1], din};

  always_comb begin
    sat_c = sum_c[REW_W-1:0];
    if (sum_c[REW_W:REW_W-1] == 2'b01) begin
      sat_c = {1'b0, {(REW_W-1){1'b1}}};
    end else if (sum_c[REW_W:REW_W-1] == 2'b10) begin
      sat_c = {1'b1, {(REW_W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sat_c;
    end
  end

endmodule

// File: rtl/rl_step_ctrl.sv
// Episode/step sequencer for an RL agent: issue action, settle, sample state,
// run the reward decider, hand the reward to the Q-update. Optional episode reward
// accumulator (ep_reward port) is enabled by defining RL_STEP_REWARD_ACCUM_EN.
module rl_step_ctrl
  import rl_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned MAX_STEPS  = 100,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ST_W-1:0]          s_a,
  input  logic [ST_W-1:0]          s_b,
  input  logic                     s_valid,
  output logic                     act_valid,
  input  logic                     act_ready,
  output logic                     rd_en,
  output logic [ST_W-1:0]          rd_s_a,
  output logic [ST_W-1:0]          rd_s_b,
  input  logic signed [REW_W-1:0]  rd_r,
  output logic                     upd_valid,
  input  logic                     upd_ready,
  output logic [REW_W-1:0]         upd_reward,
  output logic [STEP_W-1:0]        step_cnt,
  output logic                     busy,
  output logic                     ep_done
`ifdef RL_STEP_REWARD_ACCUM_EN
  ,
  output logic signed [REW_W-1:0]  ep_reward
`endif
);

  rl_state_e          state, state_nxt;
  logic [SET_W-1:0]   settle_cnt, settle_nxt;
  logic [LAT_W-1:0]   lat_cnt, lat_nxt;
  logic [STEP_W-1:0]  step_nxt;
  logic [REW_W-1:0]   rew_nxt;
  rl_obs_t            obs, obs_nxt;
  logic               rd_en_nxt;
  logic               done_nxt;

  assign rd_s_a = obs.a;
  assign rd_s_b = obs.b;

  // Next-state and datapath; abort outranks every handshake.
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    lat_nxt    = lat_cnt;
    step_nxt   = step_cnt;
    rew_nxt    = upd_reward;
    obs_nxt    = obs;
    rd_en_nxt  = 1'b0;
    done_nxt   = 1'b0;

    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      done_nxt  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = ACT;
            step_nxt  = '0;
          end
        end
        ACT: begin
          if (act_ready) begin
            state_nxt  = SETTLE;
            settle_nxt = '0;
          end
        end
        SETTLE: begin
          if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
            state_nxt = SAMPLE;
          end else begin
            settle_nxt = settle_cnt + SET_W'(1);
          end
        end
        SAMPLE: begin
          if (s_valid) begin
            obs_nxt.a = s_a;
            obs_nxt.b = s_b;
            rd_en_nxt = 1'b1;
            lat_nxt   = '0;
            state_nxt = EVAL;
          end
        end
        EVAL: begin
          // lat_cnt counts from the rd_en cycle; capture when rd_r is due.
          if (lat_cnt == LAT_W'(RD_LAT)) begin
            rew_nxt   = rd_r;
            state_nxt = UPDATE;
          end else begin
            lat_nxt = lat_cnt + LAT_W'(1);
          end
        end
        UPDATE: begin
          if (upd_ready) begin
            step_nxt = step_cnt + STEP_W'(1);
            if (step_nxt == STEP_W'(MAX_STEPS)) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = ACT;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      lat_cnt    <= '0;
      step_cnt   <= '0;
      upd_reward <= '0;
      obs        <= '0;
      rd_en      <= 1'b0;
      ep_done    <= 1'b0;
      act_valid  <= 1'b0;
      upd_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      lat_cnt    <= lat_nxt;
      step_cnt   <= step_nxt;
      upd_reward <= rew_nxt;
      obs        <= obs_nxt;
      rd_en      <= rd_en_nxt;
      ep_done    <= done_nxt;
      act_valid  <= (state_nxt == ACT);
      upd_valid  <= (state_nxt == UPDATE);
      busy       <= (state_nxt != IDLE);
    end
  end

`ifdef RL_STEP_REWARD_ACCUM_EN
  logic acc_clr_c;
  logic acc_en_c;

  assign acc_clr_c = (state == IDLE) && start;
  assign acc_en_c  = (state == EVAL) && !abort && (lat_cnt == LAT_W'(RD_LAT));

  sat_acc32 u_acc (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr_c),
    .en  (acc_en_c),
    .din (rd_r),
    .acc (ep_reward)
  );
`endif

endmodule

// File: tb/tb_rl_step_ctrl.sv
// Self-checking bench for rl_step_ctrl: scenario tasks plus a scoreboard monitor
// that checks latched samples at rd_en and rewards at each Q-update handshake.
`timescale 1ns/1ps
module tb_rl_step_ctrl;

  localparam int unsigned SETTLE_CYC = 3;
  localparam int unsigned MAX_STEPS  = 2;
  localparam int unsigned RD_LAT     = 3;

  typedef struct packed {
    logic [11:0] sa;
    logic [11:0] sb;
    logic [31:0] rew;
  } step_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] s_a = '0;
  logic [11:0] s_b = '0;
  logic        s_valid = 1'b0;
  logic        act_valid;
  logic        act_ready = 1'b0;
  logic        rd_en;
  logic [11:0] rd_s_a;
  logic [11:0] rd_s_b;
  logic [31:0] rd_r;
  logic        upd_valid;
  logic        upd_ready = 1'b0;
  logic [31:0] upd_reward;
  logic [15:0] step_cnt;
  logic        busy;
  logic        ep_done;
`ifdef RL_STEP_REWARD_ACCUM_EN
  logic [31:0] ep_reward;
`endif

  int checks = 0;
  int failures = 0;
  step_t exp_q[$];
  logic [31:0] rew_stim = '0;
  logic [RD_LAT-1:0] rd_pipe = '0;

  always #5 clk = ~clk;

  rl_step_ctrl #(
    .SETTLE_CYC (SETTLE_CYC),
    .MAX_STEPS  (MAX_STEPS),
    .RD_LAT     (RD_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .s_a        (s_a),
    .s_b        (s_b),
    .s_valid    (s_valid),
    .act_valid  (act_valid),
    .act_ready  (act_ready),
    .rd_en      (rd_en),
    .rd_s_a     (rd_s_a),
    .rd_s_b     (rd_s_b),
    .rd_r       (rd_r),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_reward (upd_reward),
    .step_cnt   (step_cnt),
    .busy       (busy),
    .ep_done    (ep_done)
`ifdef RL_STEP_REWARD_ACCUM_EN
    ,
    .ep_reward  (ep_reward)
`endif
  );

  // Reward-decider model: rd_r is valid only RD_LAT cycles after rd_en, junk otherwise.
  always @(posedge clk) rd_pipe <= {rd_pipe[RD_LAT-2:0], rd_en};
  assign rd_r = rd_pipe[RD_LAT-1] ? rew_stim : 32'h5A5A_5A5A;

  // Scoreboard: sample checked at rd_en, reward checked and popped at handshake.
  always begin
    @(negedge clk);
    #2;
    if (!rst || (abort && busy)) begin
      exp_q.delete();
    end else begin
      if (rd_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rd_sample: got rd_en with empty scoreboard, want an expected entry");
        end else if ({rd_s_a, rd_s_b} !== {exp_q[0].sa, exp_q[0].sb}) begin
          failures++;
          $display("FAIL rd_sample: got a=%h b=%h, want a=%h b=%h",
                   rd_s_a, rd_s_b, exp_q[0].sa, exp_q[0].sb);
        end
      end
      if (upd_valid && upd_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL upd_reward: got handshake with empty scoreboard, want an expected entry");
        end else begin
          if (upd_reward !== exp_q[0].rew) begin
            failures++;
            $display("FAIL upd_reward: got %h, want %h", upd_reward, exp_q[0].rew);
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_sample(input logic [11:0] sa, input logic [11:0] sb, input logic [31:0] rew);
    step_t e;
    e.sa = sa; e.sb = sb; e.rew = rew;
    s_a = sa; s_b = sb; rew_stim = rew;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic abort_episode();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({act_valid, rd_en, upd_valid, busy, ep_done} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b, want 00000", {act_valid, rd_en, upd_valid, busy, ep_done});
    end
    checks++;
    if ({step_cnt, upd_reward, rd_s_a, rd_s_b} !== 72'h0) begin
      failures++;
      $display("FAIL reset_data: got %h, want 0", {step_cnt, upd_reward, rd_s_a, rd_s_b});
    end
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_episode();
    int dones = 0;
    int hs = 0;
    int extra = 0;
    act_ready = 1'b1; upd_ready = 1'b1; s_valid = 1'b1;
    set_sample(12'h123, 12'h456, 32'd7);
    pulse_start();
    checks++;
    if ({busy, step_cnt} !== {1'b1, 16'd0}) begin
      failures++;
      $display("FAIL ep_start: got busy=%b step=%0d, want busy=1 step=0", busy, step_cnt);
    end
    for (int i = 0; i < 200 && dones == 0; i++) begin
      if (upd_valid && upd_ready) hs++;
      tick();
      if (hs == 1) begin
        hs = 2;
        checks++;
        if (step_cnt !== 16'd1) begin
          failures++;
          $display("FAIL ep_step1: got step=%0d, want 1", step_cnt);
        end
        set_sample(12'h0AB, 12'hFED, 32'hFFFF_FFEC);
      end
      if (ep_done) dones++;
    end
    checks++;
    if (dones != 1 || step_cnt !== 16'd2) begin
      failures++;
      $display("FAIL ep_done: got pulses=%0d step=%0d, want pulses=1 step=2", dones, step_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ep_done || busy) extra++;
    end
    checks++;
    if (extra != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL ep_after: got extra=%0d left=%0d, want 0 0", extra, exp_q.size());
    end
  endtask

  task automatic test_act_hold();
    int low_bad = 0;
    int cnt = 0;
    act_ready = 1'b0; upd_ready = 1'b1; s_valid = 1'b1;
    set_sample(12'h0F0, 12'h00F, 32'd100);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      if (act_valid !== 1'b1) low_bad++;
      if (i == 4) act_ready = 1'b1;
      tick();
    end
    checks++;
    if (low_bad != 0) begin
      failures++;
      $display("FAIL act_hold: got %0d cycles act_valid low, want 0", low_bad);
    end
    checks++;
    if ({act_valid, busy} !== 2'b01) begin
      failures++;
      $display("FAIL act_accept: got act_valid=%b busy=%b, want 0 1", act_valid, busy);
    end
    while (!rd_en && cnt < 20) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt != SETTLE_CYC + 1) begin
      failures++;
      $display("FAIL settle_len: got rd_en %0d cycles after accept, want %0d", cnt, SETTLE_CYC + 1);
    end
    abort_episode();
  endtask

  task automatic test_sample_wait();
    int seen = 0;
    act_ready = 1'b1; upd_ready = 1'b1; s_valid = 1'b0;
    set_sample(12'h249, 12'h1B6, 32'h100);
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      if (rd_en) seen++;
      if (i < 9) tick();
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL no_rd_en: got %0d rd_en cycles, want 0", seen);
    end
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    checks++;
    if ({rd_en, rd_s_a} !== {1'b1, 12'h249}) begin
      failures++;
      $display("FAIL sample_latch: got rd_en=%b a=%h, want 1 249", rd_en, rd_s_a);
    end
    tick();
    checks++;
    if (rd_en !== 1'b0) begin
      failures++;
      $display("FAIL rd_en_pulse: got %b, want 0", rd_en);
    end
    abort_episode();
  endtask

  task automatic test_latency();
    int cnt = 0;
    int hold_bad = 0;
    act_ready = 1'b1; upd_ready = 1'b0; s_valid = 1'b1;
    set_sample(12'h555, 12'h2AA, 32'hFFFF_FFFB);
    pulse_start();
    for (int i = 0; i < 40 && !rd_en; i++) tick();
    while (!upd_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt != RD_LAT + 1) begin
      failures++;
      $display("FAIL rd_latency: got UPDATE %0d cycles after rd_en, want %0d", cnt, RD_LAT + 1);
    end
    checks++;
    if (upd_reward !== 32'hFFFF_FFFB) begin
      failures++;
      $display("FAIL neg_reward: got %h, want FFFFFFFB", upd_reward);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (upd_valid !== 1'b1 || upd_reward !== 32'hFFFF_FFFB) hold_bad++;
    end
    checks++;
    if (hold_bad != 0) begin
      failures++;
      $display("FAIL upd_hold: got %0d unstable cycles, want 0", hold_bad);
    end
    upd_ready = 1'b1;
    tick();
    upd_ready = 1'b0;
    checks++;
    if ({upd_valid, step_cnt} !== {1'b0, 16'd1}) begin
      failures++;
      $display("FAIL upd_handshake: got valid=%b step=%0d, want 0 1", upd_valid, step_cnt);
    end
    set_sample(12'h3C3, 12'h0C0, 32'h0000_0042);
  endtask

  task automatic test_abort_update();
    for (int i = 0; i < 40 && !upd_valid; i++) tick();
    checks++;
    if ({upd_valid, upd_reward} !== {1'b1, 32'h42}) begin
      failures++;
      $display("FAIL abort_pre: got valid=%b rew=%h, want 1 00000042", upd_valid, upd_reward);
    end
    abort = 1'b1; upd_ready = 1'b1;
    tick();
    abort = 1'b0; upd_ready = 1'b0;
    checks++;
    if ({busy, ep_done, upd_valid, act_valid, step_cnt} !== {4'b0100, 16'd1}) begin
      failures++;
      $display("FAIL abort_upd: got busy=%b done=%b uv=%b av=%b step=%0d, want 0 1 0 0 1",
               busy, ep_done, upd_valid, act_valid, step_cnt);
    end
    tick();
    checks++;
    if (ep_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_pulse: got ep_done=%b, want 0", ep_done);
    end
  endtask

`ifdef RL_STEP_REWARD_ACCUM_EN
  task automatic test_accum();
    int hs = 0;
    int dones = 0;
    act_ready = 1'b1; upd_ready = 1'b1; s_valid = 1'b1;
    set_sample(12'h111, 12'h222, 32'h7FFF_FFF0);
    pulse_start();
    checks++;
    if (ep_reward !== 32'h0) begin
      failures++;
      $display("FAIL acc_clear: got %h, want 0", ep_reward);
    end
    for (int i = 0; i < 200 && dones == 0; i++) begin
      if (upd_valid && upd_ready) hs++;
      tick();
      if (hs == 1) begin
        hs = 2;
        checks++;
        if (ep_reward !== 32'h7FFF_FFF0) begin
          failures++;
          $display("FAIL acc_step1: got %h, want 7FFFFFF0", ep_reward);
        end
        set_sample(12'h333, 12'h444, 32'h0000_0100);
      end
      if (ep_done) dones++;
    end
    tick(); tick();
    checks++;
    if (dones != 1 || ep_reward !== 32'h7FFF_FFFF) begin
      failures++;
      $display("FAIL acc_sat: got pulses=%0d acc=%h, want 1 7FFFFFFF", dones, ep_reward);
    end
  endtask
`endif

  task automatic test_reset_mid_settle();
    int bad = 0;
    act_ready = 1'b1; upd_ready = 1'b1; s_valid = 1'b1;
    set_sample(12'h7E7, 12'h181, 32'h1234);
    pulse_start();
    for (int i = 0; i < 60 && !(upd_valid && upd_ready); i++) tick();
    tick();
    set_sample(12'h0AA, 12'h055, 32'h9);
    tick();
    checks++;
    if ({busy, act_valid, step_cnt, rd_s_a} !== {2'b10, 16'd1, 12'h7E7}) begin
      failures++;
      $display("FAIL mid_settle: got busy=%b av=%b step=%0d a=%h, want 1 0 1 7E7",
               busy, act_valid, step_cnt, rd_s_a);
    end
    rst = 1'b0;
    #2;
    checks++;
    if ({act_valid, rd_en, upd_valid, busy, ep_done, step_cnt, upd_reward, rd_s_a, rd_s_b} !== 77'h0) begin
      failures++;
      $display("FAIL reset_mid: got %h, want 0",
               {act_valid, rd_en, upd_valid, busy, ep_done, step_cnt, upd_reward, rd_s_a, rd_s_b});
    end
`ifdef RL_STEP_REWARD_ACCUM_EN
    checks++;
    if (ep_reward !== 32'h0) begin
      failures++;
      $display("FAIL reset_acc: got %h, want 0", ep_reward);
    end
`endif
    tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ep_done || busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_lost: got %0d cycles with ep_done/busy, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_episode();
    test_act_hold();
    test_sample_wait();
    test_latency();
    test_abort_update();
`ifdef RL_STEP_REWARD_ACCUM_EN
    test_accum();
`endif
    test_reset_mid_settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
